// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port RAM (one write port, one read port, one clock)
//   with per-byte write enables, a 1- or 2-cycle registered read pipeline
//   qualified by rd_valid, selectable read-during-write behaviour, and a
//   sequential clear engine that zeroes the array after reset or on clr_req.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   clr_req / busy      clear request pulse / clear engine running
//   we, wr_addr, wr_din, wr_be      write port with byte-lane enables
//   re, rd_addr, rd_dout, rd_valid  read port; rd_dout holds between reads
module ram_dp_be #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // Storage: deliberately not reset; the clear engine zeroes it instead.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // Set once the last entry has been cleared; the FSM leaves CLEAR one
  // edge later so busy spans DEPTH+1 edges while cnt saturates.
  logic                  last_q, last_d;
  logic                  clr_we;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        if (last_q) begin
          state_d = S_IDLE;
        end else begin
          clr_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  assign busy = (state_q == S_CLEAR);

  // ---------------------------------------------------------------------------
  // Address range checks. When the array fills the whole address space every
  // address is valid, so no comparator is built.
  // ---------------------------------------------------------------------------
  generate
    if (DEPTH >= (1 << ADDR_WIDTH)) begin : g_full_range
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_part_range
      localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
      assign wr_in_range = (wr_addr < DEPTH_A);
      assign rd_in_range = (rd_addr < DEPTH_A);
    end
  endgenerate

  // User traffic is locked out for the whole time the clear engine runs.
  assign wr_ok = we && !busy && wr_in_range;
  assign rd_ok = re && !busy;

  // ---------------------------------------------------------------------------
  // Array write port: clear writes and user writes never coincide because
  // user writes are gated by busy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_din[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read word selection. Out-of-range reads return zero. In bypass mode a
  // same-address write is merged lane by lane into the returned word.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_old = '0;
    if (rd_in_range) begin
      rd_old = mem[rd_addr];
    end
  end

  always_comb begin
    wr_merged = rd_old;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (wr_be[i]) begin
        wr_merged[8*i +: 8] = wr_din[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = rd_old;
    if ((RDW_MODE == 1) && wr_ok && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Data is captured at the accepting edge, so reads that were
  // accepted just before a clear still return pre-clear contents.
  // ---------------------------------------------------------------------------
  generate
    if (RD_LATENCY == 2) begin : g_rd_lat2
      logic                  s1_vld;
      logic [DATA_WIDTH-1:0] s1_dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld   <= 1'b0;
          s1_dat   <= '0;
          rd_valid <= 1'b0;
          rd_dout  <= '0;
        end else begin
          s1_vld   <= rd_ok;
          if (rd_ok) begin
            s1_dat <= rd_word;
          end
          rd_valid <= s1_vld;
          if (s1_vld) begin
            rd_dout <= s1_dat;
          end
        end
      end
    end else begin : g_rd_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid <= 1'b0;
          rd_dout  <= '0;
        end else begin
          rd_valid <= rd_ok;
          if (rd_ok) begin
            rd_dout <= rd_word;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ram_dp_be.sv
// Testbench for ram_dp_be: two instances share stimulus, one with 1-cycle read
// latency and old-data read-during-write, one with 2-cycle latency and bypass.
// A behavioural memory model with per-instance expected-read queues checks
// every cycle; a vector table and directed sequences cover the corner cases.
module tb_ram_dp_be;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BW    = DW / 8;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          clr_req = 1'b0;
  logic          we      = 1'b0;
  logic          re      = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_din  = '0;
  logic [BW-1:0] wr_be   = '0;

  logic          busy_a, busy_b, vld_a, vld_b;
  logic [DW-1:0] dout_a, dout_b;

  always #5 clk = ~clk;

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
              .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_a), .rd_valid(vld_a)
  );

  ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
              .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b),
    .we(we), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .re(re), .rd_addr(rd_addr), .rd_dout(dout_b), .rd_valid(vld_b)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  rd_t           qa[$];
  rd_t           qb[$];
  logic [DW-1:0] mmem [DEPTH];
  int            clr_left = 0;
  int            cyc      = 0;
  logic [DW-1:0] last_a   = '0;
  logic [DW-1:0] last_b   = '0;
  int            tests    = 0;
  int            fails    = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be,
                       input logic r, input logic [AW-1:0] ra, input logic c);
    we = w; wr_addr = wa; wr_din = wd; wr_be = be;
    re = r; rd_addr = ra; clr_req = c;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // One clock: update the model with the inputs sampled at this edge, then
  // compare all outputs 1 time unit later.
  task automatic step();
    logic [DW-1:0] old_w, merged;
    rd_t           e;
    logic          ev;
    @(posedge clk);
    cyc++;
    if (clr_left > 0) begin
      clr_left--;
    end else begin
      merged = mmem[wr_addr];
      for (int i = 0; i < BW; i++)
        if (wr_be[i]) merged[8*i +: 8] = wr_din[8*i +: 8];
      if (re) begin
        old_w = mmem[rd_addr];
        e.due = cyc;     e.d = old_w;                                   qa.push_back(e);
        e.due = cyc + 1; e.d = (we && wr_addr == rd_addr) ? merged : old_w; qb.push_back(e);
      end
      if (we) mmem[wr_addr] = merged;
      if (clr_req) begin
        clr_left = DEPTH + 1;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
      end
    end
    #1;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    if (ev) begin e = qa.pop_front(); last_a = e.d; end
    chk("vld_a", 32'(vld_a), 32'(ev));
    chk("dout_a", dout_a, last_a);
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    if (ev) begin e = qb.pop_front(); last_b = e.d; end
    chk("vld_b", 32'(vld_b), 32'(ev));
    chk("dout_b", dout_b, last_b);
    chk("busy_a", 32'(busy_a), 32'(clr_left > 0));
    chk("busy_b", 32'(busy_b), 32'(clr_left > 0));
  endtask

  // Assert reset mid-cycle, check outputs react without a clock edge,
  // release, then count edges until busy falls.
  task automatic do_reset();
    int n;
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_dout_a", dout_a, '0);
    chk("rst_dout_b", dout_b, '0);
    chk("rst_vld", 32'({vld_a, vld_b}), 32'(0));
    chk("rst_busy", 32'({busy_a, busy_b}), 32'(3));
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_left = DEPTH + 1;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    n = 0;
    while (busy_a && n < 40) begin
      step();
      n++;
    end
    chk("busy_edges", 32'(n), 32'(DEPTH + 1));
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic          w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [BW-1:0] be;
    logic          r;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_a;   // old-data instance
    logic [DW-1:0] exp_b;   // bypass instance
  } vec_t;

  initial begin
    vec_t tab[10];
    int   va, vb;

    tab[0] = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF,    1'b0, 4'd0, 32'h0,        32'h0};
    tab[1] = '{1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, 32'h0,        32'h0};
    tab[2] = '{1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
    tab[3] = '{1'b1, 4'd7, 32'hA5A5A5A5, 4'hF,    1'b1, 4'd7, 32'h00000000, 32'hA5A5A5A5};
    tab[4] = '{1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tab[5] = '{1'b1, 4'd5, 32'hCAFEF00D, 4'b1000, 1'b1, 4'd5, 32'h00000000, 32'hCA000000};
    tab[6] = '{1'b1, 4'd5, 32'h12345678, 4'b0000, 1'b1, 4'd5, 32'hCA000000, 32'hCA000000};
    tab[7] = '{1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd5, 32'hCA000000, 32'hCA000000};
    tab[8] = '{1'b1, 4'd9, 32'h01020304, 4'b0011, 1'b1, 4'd3, 32'hDE22BE44, 32'hDE22BE44};
    tab[9] = '{1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd9, 32'h00000304, 32'h00000304};

    #2;
    // Power-up reset and clear timing; every word reads back zero, issued
    // back to back so the pulse trains and first-pulse latency are visible.
    do_reset();
    va = 0; vb = 0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
      step();
      if (a == 0) begin
        chk("first_vld_a", 32'(vld_a), 32'(1));
        chk("first_vld_b", 32'(vld_b), 32'(0));
      end
      chk("init_zero_a", dout_a, '0);
      va += int'(vld_a); vb += int'(vld_b);
    end
    for (int k = 0; k < 2; k++) begin
      idle(); step();
      va += int'(vld_a); vb += int'(vld_b);
    end
    chk("b2b_pulses_a", 32'(va), 32'(DEPTH));
    chk("b2b_pulses_b", 32'(vb), 32'(DEPTH));

    // Vector table: byte enables, read-during-write in both modes.
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].w, tab[i].wa, tab[i].wd, tab[i].be, tab[i].r, tab[i].ra, 1'b0);
      step();
      chk("tab_vld_a", 32'(vld_a), 32'(tab[i].r));
      if (tab[i].r) chk("tab_dout_a", dout_a, tab[i].exp_a);
      idle();
      step();
      chk("tab_vld_b", 32'(vld_b), 32'(tab[i].r));
      if (tab[i].r) chk("tab_dout_b", dout_b, tab[i].exp_b);
    end

    // Randomised traffic with address collisions and occasional clears.
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      drive(1'($urandom_range(0, 1)), wa, $urandom, BW'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 59) == 0));
      step();
    end
    idle();
    while (clr_left > 0) step();

    // Fill, then clear with a read issued on the same edge as clr_req, and
    // hammer the ports (and clr_req) while busy.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, AW'(a), $urandom | 32'h1, 4'hF, 1'b0, '0, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b1);
    step();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom | 32'h1, 4'hF,
            1'b1, AW'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)));
      step();
    end
    idle();
    step();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
      step();
      chk("clr_zero_a", dout_a, '0);
    end
    idle(); step(); step();

    // Reset in the middle of a clear, with non-zero data on the outputs.
    drive(1'b1, 4'd3, 32'h13572468, 4'hF, 1'b0, '0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    step();
    idle(); step();
    chk("pre_rst_dout_b", dout_b, 32'h13572468);
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    step();
    idle();
    repeat (8) step();
    do_reset();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
      step();
      chk("rst_clr_zero_a", dout_a, '0);
    end
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
